// File: rtl/cache_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cache_set_ctrl
// Brief   : N-way cache set sequencer (MESI tag store, tree-PLRU, bus ops).
//           Define CACHE_SET_PRINT_EN for cmd-9 way dump and bus op trace.
// Revision: 1.0  initial release
// ============================================================================
module cache_set_ctrl #(
   parameter int WAYS  = 4,
   parameter int TAG_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_n,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             bus_req_valid,
   input  logic             bus_req_ready,
   output logic [1:0]       bus_req_op,
   output logic [TAG_W-1:0] bus_req_tag,
   input  logic [1:0]       snoop_result,
   output logic             done,
   output logic             done_hit,
   output logic [1:0]       put_snoop
);
   localparam int c_WAY_W = $clog2(WAYS);

   localparam logic [2:0] c_IDLE = 3'd0, c_LOOKUP = 3'd1, c_WB = 3'd2, c_BUS = 3'd3, c_UPDATE = 3'd4;
   localparam logic [1:0] c_I = 2'd0, c_S = 2'd1, c_E = 2'd2, c_M = 2'd3;
   localparam logic [1:0] c_OP_READ = 2'd0, c_OP_WRITE = 2'd1, c_OP_INV = 2'd2, c_OP_RFO = 2'd3;
   localparam logic [1:0] c_SN_HIT = 2'd0, c_SN_NOHIT = 2'd1, c_SN_HITM = 2'd2;

   logic [2:0]         r_state, w_next_state;
   logic [TAG_W-1:0]   r_tag  [WAYS];
   logic [1:0]         r_mesi [WAYS];
   logic [WAYS-2:0]    r_plru;
   logic [3:0]         r_cmd;
   logic [TAG_W-1:0]   r_ctag;
   logic               r_hit;
   logic [c_WAY_W-1:0] r_way;
   logic [1:0]         r_way_mesi;
   logic [1:0]         r_bus_op;
   logic [1:0]         r_snoop;

   logic [WAYS-1:0]    w_match, w_free;
   logic               w_hit, w_need_wb, w_need_bus;
   logic [c_WAY_W-1:0] w_hit_way, w_free_way, w_plru_way, w_way;
   logic [1:0]         w_way_mesi, w_bus_op;
   logic [WAYS-2:0]    w_plru_touch;

   for (genvar g = 0; g < WAYS; g++) begin : g_cmp
      assign w_match[g] = (r_mesi[g] != c_I) && (r_tag[g] == r_ctag);
      assign w_free[g]  = (r_mesi[g] == c_I);
   end

   // Hit way, lowest free way, and the PLRU-selected way (walk from the root)
   always_comb begin
      logic [c_WAY_W-1:0] node;
      w_hit_way  = '0;
      w_free_way = '0;
      w_plru_way = '0;
      for (int i = WAYS-1; i >= 0; i--) begin
         if (w_match[i]) w_hit_way = c_WAY_W'(i);
         if (w_free[i])  w_free_way = c_WAY_W'(i);
      end
      node = '0;
      for (int lvl = c_WAY_W-1; lvl >= 0; lvl--) begin
         w_plru_way[lvl] = r_plru[node];
         node = (node << 1) + c_WAY_W'(1) + c_WAY_W'(r_plru[node]);
      end
      w_hit      = |w_match;
      w_way      = w_hit ? w_hit_way : ((|w_free) ? w_free_way : w_plru_way);
      w_way_mesi = r_mesi[w_way];
   end

   always_comb begin
      logic [c_WAY_W-1:0] node;
      w_plru_touch = r_plru;
      node = '0;
      for (int lvl = c_WAY_W-1; lvl >= 0; lvl--) begin
         w_plru_touch[node] = ~r_way[lvl];
         node = (node << 1) + c_WAY_W'(1) + c_WAY_W'(r_way[lvl]);
      end
   end

   always_comb begin
      w_need_wb  = 1'b0;
      w_need_bus = 1'b0;
      w_bus_op   = c_OP_READ;
      case (r_cmd)
         4'd0, 4'd2: if (!w_hit) begin
            w_need_wb  = (w_way_mesi == c_M);
            w_need_bus = 1'b1;
         end
         4'd1: begin
            if (w_hit) begin
               w_need_bus = (w_way_mesi == c_S);
               w_bus_op   = c_OP_INV;
            end else begin
               w_need_wb  = (w_way_mesi == c_M);
               w_need_bus = 1'b1;
               w_bus_op   = c_OP_RFO;
            end
         end
         4'd4, 4'd6: if (w_hit && w_way_mesi == c_M) begin
            w_need_bus = 1'b1;
            w_bus_op   = c_OP_WRITE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:   if (cmd_valid) w_next_state = c_LOOKUP;
         c_LOOKUP: w_next_state = w_need_wb ? c_WB : (w_need_bus ? c_BUS : c_UPDATE);
         c_WB:     if (bus_req_ready) w_next_state = c_BUS;
         c_BUS:    if (bus_req_ready) w_next_state = c_UPDATE;
         c_UPDATE: w_next_state = c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready     = (r_state == c_IDLE);
      bus_req_valid = (r_state == c_WB) || (r_state == c_BUS);
      bus_req_op    = c_OP_READ;
      bus_req_tag   = '0;
      done          = 1'b0;
      done_hit      = 1'b0;
      put_snoop     = c_SN_HIT;
      if (r_state == c_WB) begin
         bus_req_op  = c_OP_WRITE;
         bus_req_tag = r_tag[r_way];
      end else if (r_state == c_BUS) begin
         bus_req_op  = r_bus_op;
         bus_req_tag = r_ctag;
      end
      if (r_state == c_UPDATE) begin
         done     = 1'b1;
         done_hit = r_hit && (r_cmd != 4'd8);
         case (r_cmd)
            4'd4, 4'd6: put_snoop = !r_hit ? c_SN_NOHIT : ((r_way_mesi == c_M) ? c_SN_HITM : c_SN_HIT);
            4'd5:       put_snoop = c_SN_NOHIT;
            default:    put_snoop = c_SN_HIT;
         endcase
      end
   end

   // Way state only moves in UPDATE; write hits keep the replacement order as is
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WAYS; i++) begin
            r_tag[i]  <= '0;
            r_mesi[i] <= c_I;
         end
         r_plru     <= '0;
         r_cmd      <= '0;
         r_ctag     <= '0;
         r_hit      <= 1'b0;
         r_way      <= '0;
         r_way_mesi <= c_I;
         r_bus_op   <= c_OP_READ;
         r_snoop    <= c_SN_HIT;
      end else begin
         case (r_state)
            c_IDLE: if (cmd_valid) begin
               r_cmd  <= cmd_n;
               r_ctag <= cmd_tag;
            end
            c_LOOKUP: begin
               r_hit      <= w_hit;
               r_way      <= w_way;
               r_way_mesi <= w_way_mesi;
               r_bus_op   <= w_bus_op;
            end
            c_BUS: if (bus_req_ready) r_snoop <= snoop_result;
            c_UPDATE: begin
               case (r_cmd)
                  4'd0, 4'd2: begin
                     if (!r_hit) begin
                        r_tag[r_way]  <= r_ctag;
                        r_mesi[r_way] <= (r_snoop == c_SN_NOHIT) ? c_E : c_S;
                     end
                     r_plru <= w_plru_touch;
                  end
                  4'd1: begin
                     r_mesi[r_way] <= c_M;
                     if (!r_hit) begin
                        r_tag[r_way] <= r_ctag;
                        r_plru       <= w_plru_touch;
                     end
                  end
                  4'd3: if (r_hit && r_way_mesi == c_S) r_mesi[r_way] <= c_I;
                  4'd4: if (r_hit) r_mesi[r_way] <= c_S;
                  4'd6: if (r_hit) r_mesi[r_way] <= c_I;
                  4'd8: begin
                     for (int i = 0; i < WAYS; i++) r_mesi[i] <= c_I;
                     r_plru <= '0;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_SET_PRINT_EN
   function automatic logic [7:0] f_mesi_chr(input logic [1:0] m);
      case (m)
         c_S:     return "S";
         c_E:     return "E";
         c_M:     return "M";
         default: return "I";
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst && r_state == c_UPDATE && r_cmd == 4'd9) begin
         for (int i = 0; i < WAYS; i++)
            $display("way %0d tag %h %c plru %b", i, r_tag[i], f_mesi_chr(r_mesi[i]), r_plru);
      end
      if (!rst && bus_req_valid && bus_req_ready)
         $display("bus op %0d tag %h", bus_req_op, bus_req_tag);
   end
`endif

endmodule
`default_nettype wire
